// File: rtl/pipe_io_pkg.sv
// pipe_io_pkg: register map, STATUS bit positions and TX FSM encoding shared by the pipe I/O peripherals
package pipe_io_pkg;
   localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_00A0;
   localparam logic [31:0] OFF_TXDATA    = 32'h0;
   localparam logic [31:0] OFF_STATUS    = 32'h4;
   localparam logic [31:0] OFF_BAUDDIV   = 32'h8;
   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_t;
endpackage

// File: rtl/pipe_uart_fifo.sv
// pipe_uart_fifo: synchronous TX byte FIFO
//   clock/resetn : clock, asynchronous active-low reset
//   push/din     : write din (caller guarantees !full)
//   pop/dout     : dout is the head; pop advances it (caller guarantees !empty)
//   full/empty/count : occupancy
module pipe_uart_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 8
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   always_ff @(posedge clock)
      if (push) mem[wp] <= din;
   assign dout = mem[rp];
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/pipe_uart_tx.sv
// pipe_uart_tx: memory-mapped UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined)
//   clock/resetn : CPU clock, asynchronous active-low reset
//   wmem/addr/datain : MEM-stage store strobe, byte address, store data
//   dataout/hit  : combinational read data and window decode for the load mux
//   txd          : registered serial line, idle high
//   busy         : frame in progress or FIFO non-empty
module pipe_uart_tx
   import pipe_io_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        wmem,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   output logic [31:0] dataout,
   output logic        hit,
   output logic        txd,
   output logic        busy
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   tx_state_t state, state_d;
   logic [15:0] div, cnt, cnt_d;
   logic [2:0] idx, idx_d;
   logic [7:0] sh, sh_d, head;
   logic [31:0] off, status;
   logic [CW-1:0] fcnt;
   logic sel_tx, sel_st, sel_bd, push, pop, full, empty, ovf, txd_d;
   logic unused_hi;
   assign off = addr - BASE_ADDR;
   assign sel_tx = off == OFF_TXDATA;
   assign sel_st = off == OFF_STATUS;
   assign sel_bd = off == OFF_BAUDDIV;
   assign hit = sel_tx | sel_st | sel_bd;
   assign busy = state != S_IDLE || fcnt != '0;
   // full is sampled before any same-cycle pop, so a store into a full FIFO is always dropped
   assign push = wmem && sel_tx && !full;
   assign unused_hi = ^datain[31:16];
   always_comb begin
      status = '0;
      status[ST_EMPTY] = empty;
      status[ST_FULL] = full;
      status[ST_BUSY] = busy;
      status[ST_OVF] = ovf;
   end
   assign dataout = sel_st ? status : sel_bd ? {16'd0, div} : '0;
   pipe_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clock(clock), .resetn(resetn), .push(push), .pop(pop), .din(datain[7:0]),
      .dout(head), .full(full), .empty(empty), .count(fcnt)
   );
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         div <= DEFAULT_DIV;
         ovf <= 1'b0;
      end else begin
         if (wmem && sel_bd) div <= datain[15:0];
         if (wmem && sel_tx && full) ovf <= 1'b1;
         else if (wmem && sel_st && datain[ST_OVF]) ovf <= 1'b0;
      end
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         state <= S_IDLE;
         cnt <= '0;
         idx <= '0;
         sh <= '0;
         txd <= 1'b1;
      end else begin
         state <= state_d;
         cnt <= cnt_d;
         idx <= idx_d;
         sh <= sh_d;
         txd <= txd_d;
      end
   // every bit reloads the divider on entry, so BAUDDIV writes land at the next bit boundary
   always_comb begin
      state_d = state;
      cnt_d = cnt - 16'd1;
      idx_d = idx;
      sh_d = sh;
      pop = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_d = cnt;
            if (!empty) begin
               state_d = S_START;
               pop = 1'b1;
               sh_d = head;
               cnt_d = div;
            end
         end
         S_START: if (cnt == '0) begin
            state_d = S_DATA;
            idx_d = '0;
            cnt_d = div;
         end
         S_DATA: if (cnt == '0) begin
            cnt_d = div;
            idx_d = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
            state_d = idx == 3'd7 ? S_PARITY : S_DATA;
`else
            state_d = idx == 3'd7 ? S_STOP : S_DATA;
`endif
         end
         S_PARITY: if (cnt == '0) begin
            state_d = S_STOP;
            cnt_d = div;
         end
         S_STOP: if (cnt == '0) begin
            cnt_d = div;
            state_d = empty ? S_IDLE : S_START;
            pop = !empty;
            sh_d = empty ? sh : head;
         end
         default: state_d = S_IDLE;
      endcase
   end
   // txd is registered from the next state so the line changes on the same edge as the state
   always_comb
      txd_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? sh_d[idx_d] : state_d == S_PARITY ? ^sh_d : 1'b1;
endmodule

// File: tb/tb_pipe_uart_tx.sv
// tb_pipe_uart_tx: randomized bench for pipe_uart_tx against a frame-schedule model (honours UART_TX_PARITY_EN)
module tb_pipe_uart_tx;
   localparam logic [31:0] BASE = 32'h0000_00A0;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic wmem = 1'b0;
   logic [31:0] addr = BASE + 32'h4;
   logic [31:0] datain = '0;
   logic [31:0] dataout;
   logic hit, txd, busy;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_e[$];
   logic [7:0] acc_b[$];
   int dw_e[$];
   logic [15:0] dw_v[$];
   int st[$];
   int en[$];
   bit ovf_m = 1'b0;

   pipe_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd433)) dut (
      .clock(clock), .resetn(resetn), .wmem(wmem), .addr(addr), .datain(datain),
      .dataout(dataout), .hit(hit), .txd(txd), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // divider in force for a bit loaded at edge l: last write strictly before l
   function automatic int div_at(int l);
      int d = 433;
      foreach (dw_e[i]) if (dw_e[i] < l) d = int'(dw_v[i]);
      return d;
   endfunction

   // frame k starts one edge after its store or right at the previous frame's end
   function automatic void calc();
      int b;
      st.delete();
      en.delete();
      foreach (acc_e[k]) begin
         b = acc_e[k] + 1;
         if (k > 0 && en[k-1] > b) b = en[k-1];
         st.push_back(b);
         for (int j = 0; j < NB; j++) b += div_at(b) + 1;
         en.push_back(b);
      end
   endfunction

   function automatic logic fbit(int k, int j);
      logic [7:0] d = acc_b[k];
      if (j == 0) return 1'b0;
      if (j <= 8) return d[j-1];
      if (j == 9 && NB == 11) return ^d;
      return 1'b1;
   endfunction

   function automatic logic exp_txd(int e);
      int b;
      foreach (st[k]) if (st[k] <= e && e < en[k]) begin
         b = st[k];
         for (int j = 0; j < NB; j++) begin
            b += div_at(b) + 1;
            if (e < b) return fbit(k, j);
         end
      end
      return 1'b1;
   endfunction

   function automatic int occ_after(int e);
      int n = 0;
      foreach (acc_e[k]) if (acc_e[k] <= e && st[k] > e) n++;
      return n;
   endfunction

   function automatic logic busy_m(int e);
      foreach (acc_e[k]) if (acc_e[k] <= e && e < en[k]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic win(logic [31:0] a);
      return a == BASE || a == BASE + 32'h4 || a == BASE + 32'h8;
   endfunction

   function automatic logic [31:0] exp_dout(int e);
      int occ = occ_after(e);
      if (addr == BASE + 32'h4) return {28'd0, ovf_m, busy_m(e), occ == DEPTH, occ == 0};
      if (addr == BASE + 32'h8) return {16'd0, 16'(div_at(e + 1))};
      return 32'd0;
   endfunction

   task automatic tick();
      @(posedge clock);
      cyc++;
      #1;
      calc();
      check("txd", 32'(txd), 32'(exp_txd(cyc)));
      check("busy", 32'(busy), 32'(busy_m(cyc)));
      check("hit", 32'(hit), 32'(win(addr)));
      check("dataout", dataout, exp_dout(cyc));
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      int e = cyc + 1;
      calc();
      if (a == BASE) begin
         if (e - 1 >= 0 && occ_before(e) < DEPTH) begin
            acc_e.push_back(e);
            acc_b.push_back(d[7:0]);
         end else ovf_m = 1'b1;
      end else if (a == BASE + 32'h4) begin
         if (d[3]) ovf_m = 1'b0;
      end else if (a == BASE + 32'h8) begin
         dw_e.push_back(e);
         dw_v.push_back(d[15:0]);
      end
      wmem = 1'b1;
      addr = a;
      datain = d;
      tick();
      wmem = 1'b0;
      addr = BASE + 32'h4;
   endtask

   function automatic int occ_before(int e);
      int n = 0;
      foreach (acc_e[k]) if (acc_e[k] < e && st[k] >= e) n++;
      return n;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(5))
         0: return BASE;
         1: return BASE + 32'h4;
         2: return BASE + 32'h8;
         3: return BASE + 32'hC;
         4: return BASE - 32'h4;
         default: return $urandom & 32'hFFFF_FFFC;
      endcase
   endfunction

   initial begin
      logic [31:0] a;
      idle(2);
      addr = BASE + 32'h8;
      idle(1);
      addr = BASE + 32'h4;
      resetn = 1'b1;
      idle(2);
      wr(BASE + 32'h8, 32'd3);
      wr(BASE, 32'h55);
      idle(50);
      for (int i = 1; i <= 5; i++) wr(BASE, 32'(i));
      wr(BASE, 32'hFF);
      wr(BASE + 32'h4, 32'h8);
      idle(240);
      wr(BASE, 32'hA5);
      idle(2);
      wr(BASE + 32'h8, 32'd7);
      idle(100);
      wr(BASE + 32'h8, 32'd3);
      wr(BASE, 32'h07);
      idle(50);
      wr(BASE, 32'h03);
      idle(50);
      addr = 32'h0000_0010;
      idle(1);
      addr = BASE + 32'hC;
      idle(1);
      wr(BASE, 32'h3C);
      idle(22);
      #2 resetn = 1'b0;
      acc_e.delete();
      acc_b.delete();
      dw_e.delete();
      dw_v.delete();
      ovf_m = 1'b0;
      calc();
      #1;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_status", dataout, 32'h1);
      addr = BASE + 32'h8;
      #1;
      check("rst_div", dataout, 32'd433);
      idle(2);
      resetn = 1'b1;
      addr = BASE + 32'h4;
      wr(BASE + 32'h8, 32'd1);
      for (int i = 0; i < 1000; i++) begin
         a = pick();
         if ($urandom_range(99) < 35) wr(a, a == BASE + 32'h8 ? 32'($urandom_range(3)) : $urandom);
         else begin
            addr = a;
            tick();
         end
      end
      addr = BASE + 32'h4;
      idle(500);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
